loop_vertex_smoother: RTL and testbench
=======================================

# loop_vertex_smoother

Parametrised successor of the single-pass vertex averager. For each vertex it reads valence and neighbour indices from the neighbour RAM and fetches coordinates from the object RAM. It then computes the Loop-subdivision even-vertex position in signed fixed point, with the exact Loop beta weight rather than a shift approximation, and writes the result to the result RAM. It sits after the adjacency builder in the subdivision pipeline and adds copy mode, malformed-valence detection, synchronous reset and a done pulse.

## Interface
- ADDR_WIDTH, 9: word address width of all three RAMs
- DATA_WIDTH, 32: coordinate word width, signed two's complement
- FRAC_BITS, 16: fractional bits of coordinates and weights
- MAX_NEIGHBOR_COUNT, 10: maximum valence; neighbour-RAM stride is MAX_NEIGHBOR_COUNT+1 words
- clk in 1: the block's only clock; all logic on rising edge
- rst in 1: reset, synchronous, active-high
- start in 1: one-cycle request; sampled only in IDLE
- mode in 1: 0 = Loop smoothing, 1 = copy; sampled with start
- vertex_count in 32: number of vertices; sampled with start
- RAM_OBJ_EN / RAM_OBJ_A out 1 / ADDR_WIDTH: object RAM read port
- RAM_OBJ_Do in DATA_WIDTH: object RAM read data
- RAM_NBR_EN / RAM_NBR_A out 1 / ADDR_WIDTH: neighbour RAM read port
- RAM_NBR_Do in 32: neighbour RAM read data
- RAM_RES_EN / RAM_RES_A / RAM_RES_WE / RAM_RES_Di out 1 / ADDR_WIDTH / 4 / DATA_WIDTH: result RAM write port
- busy out 1: run in progress
- done out 1: one-cycle pulse at end of run
- err out 1: sticky malformed-valence flag, cleared by the next accepted start

## Operation
- Memory layout:
  - Vertex v (0-based) coordinates sit at object/result addresses 3v+1, 3v+2, 3v+3.
  - Neighbour base for v is v*(MAX_NEIGHBOR_COUNT+1): word 0 holds valence n, words 1..n hold 1-based vertex indices k, with coordinates at 3k-2..3k.
- States:
  - IDLE: start=1 moves to LD_CNT. If vertex_count=0, go straight to DONE instead.
  - LD_CNT: issue the count read, capture n.
  - LD_IDX: issue an index read, capture k.
  - FETCH_NBR: read x, y, z of neighbour k, accumulate.
  - FETCH_SELF: read x, y, z of vertex v, accumulate.
  - WRITE: write x, y, z to the result RAM.
  - NEXT: v+1; back to LD_CNT, or to DONE when v reaches vertex_count.
  - DONE: one cycle, then IDLE.
- Skip rules:
  - If n=0, n>MAX_NEIGHBOR_COUNT, or mode=1, skip LD_IDX/FETCH_NBR and use self weight 1.0.
  - For the two invalid-n cases only, also set err.
- Weights (elaboration-time table, index n=1..MAX_NEIGHBOR_COUNT):
  - beta(3) = floor(3·2^F/16); beta(n) = floor(3·2^F/(8n)) otherwise.
  - w_self = 2^F − n·beta(n).
  - Weights sum to exactly 2^F, so |result| ≤ max |input|; no saturation logic.
- Arithmetic:
  - Products are signed DATA_WIDTH×(FRAC_BITS+2) multiplications.
  - Accumulators are 2·DATA_WIDTH+clog2(MAX_NEIGHBOR_COUNT+1) bits, one each for x, y, z, cleared in LD_CNT.
  - Result = accumulator >>> FRAC_BITS (arithmetic shift, floor), truncated to DATA_WIDTH.
- Enables: EN for each RAM is high while busy; the object and neighbour ports never write.
- start while busy is ignored.

## Timing
- RAM read latency is 1 cycle: data for an address driven in cycle t is sampled in cycle t+1.
- Phase cycle counts:
  - LD_CNT: 2 cycles.
  - LD_IDX: 2 cycles.
  - FETCH_NBR / FETCH_SELF: 4 cycles, pipelined (issue x; issue y + capture x; issue z + capture y; capture z).
  - WRITE: 3 cycles, WE=4'b1111 on each.
  - NEXT: 0 cycles (merged into the last WRITE cycle).
- Per vertex: 9+6n cycles in Loop mode with valid n; 9 cycles when skipped.
- Run timing:
  - start accepted at edge 0; busy=1 from cycle 1.
  - done=1 and busy=0 in the cycle after the last write.
  - vertex_count=0: done at cycle 1, no writes.
- Reset (rst=1 at an edge, including mid-run) gives, from the next cycle:
  - busy=0, done=0, err=0.
  - all EN=0, all A=0, RAM_RES_WE=0, RAM_RES_Di=0.
  - state IDLE, no further writes.
- These are also the power-up values after the first reset.

## Test plan
- 1.0=0x10000:
  - Stimulus: Loop, vertex_count=1, n=3, self (0,0,0), three neighbours (1.0,0,0).
  - Response: result (0x9000,0,0) at addresses 1..3; busy 27 cycles; done pulse.
- Valence 6:
  - Stimulus: self (2.0,2.0,2.0), six neighbours at 0.
  - Response: beta=0x1000, w_self=0xA000; result 0x14000 on all axes.
  - Repeat with self −2.0: result −1.25 (0xFFFEC000).
- Copy mode:
  - Stimulus: mode=1, vertex_count=4, arbitrary valences.
  - Response: result words 1..12 equal object words 1..12; err=0; run length 36 cycles.
- Malformed valence:
  - Stimulus: vertex_count=2, vertex 0 valid n=3, vertex 1 n=0; then a second run with n=11.
  - Response: vertex 1 copied unchanged and err=1, vertex 0 smoothed; n=11 also copies and sets err.
  - Next start clears err.
- Reset mid-WRITE:
  - Stimulus: assert rst on the second write cycle.
  - Response: next cycle WE=0, busy=0, no done pulse.
  - Restart reproduces the full results from scenario 1.
- Start while busy:
  - Stimulus: pulse start mid-run with a different vertex_count.
  - Response: ignored; original run completes with a single done pulse.

Source files
------------

// File: rtl/loop_vertex_smoother_if.sv
// loop_vertex_smoother_if
// Bundles the three RAM ports used by the Loop vertex smoother.
//   Object RAM    : RAM_OBJ_EN / RAM_OBJ_A out, RAM_OBJ_Do in (1-cycle read latency)
//   Neighbour RAM : RAM_NBR_EN / RAM_NBR_A out, RAM_NBR_Do in (1-cycle read latency)
//   Result RAM    : RAM_RES_EN / RAM_RES_A / RAM_RES_WE / RAM_RES_Di out (write only)
// The master modport is the smoother; the slave modport is the memory side.
interface loop_vertex_smoother_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                  RAM_OBJ_EN;
  logic [ADDR_WIDTH-1:0] RAM_OBJ_A;
  logic [DATA_WIDTH-1:0] RAM_OBJ_Do;

  logic                  RAM_NBR_EN;
  logic [ADDR_WIDTH-1:0] RAM_NBR_A;
  logic [31:0]           RAM_NBR_Do;

  logic                  RAM_RES_EN;
  logic [ADDR_WIDTH-1:0] RAM_RES_A;
  logic [3:0]            RAM_RES_WE;
  logic [DATA_WIDTH-1:0] RAM_RES_Di;

  modport master (
    output RAM_OBJ_EN, RAM_OBJ_A,
    input  RAM_OBJ_Do,
    output RAM_NBR_EN, RAM_NBR_A,
    input  RAM_NBR_Do,
    output RAM_RES_EN, RAM_RES_A, RAM_RES_WE, RAM_RES_Di
  );

  modport slave (
    input  RAM_OBJ_EN, RAM_OBJ_A,
    output RAM_OBJ_Do,
    input  RAM_NBR_EN, RAM_NBR_A,
    output RAM_NBR_Do,
    input  RAM_RES_EN, RAM_RES_A, RAM_RES_WE, RAM_RES_Di
  );
endinterface

// File: rtl/loop_vertex_smoother.sv
// loop_vertex_smoother
// Computes the Loop-subdivision even-vertex position of every vertex of a mesh.
// For each vertex it reads the valence and neighbour indices from the neighbour
// RAM, fetches coordinates from the object RAM, forms the weighted sum in signed
// fixed point with the exact Loop beta weights, and writes x/y/z to the result RAM.
// Copy mode (mode=1) and malformed valences (0 or above MAX_NEIGHBOR_COUNT) pass
// the vertex through with weight 1.0; malformed valences also raise err.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   start        : one-cycle run request, sampled only when idle
//   mode         : 0 = Loop smoothing, 1 = copy (sampled with start)
//   vertex_count : number of vertices in the run (sampled with start)
//   ram          : object / neighbour read ports and result write port
//   busy         : run in progress
//   done         : one-cycle pulse after the last result write
//   err          : sticky malformed-valence flag, cleared by the next accepted start
module loop_vertex_smoother #(
  parameter int ADDR_WIDTH         = 9,
  parameter int DATA_WIDTH         = 32,
  parameter int FRAC_BITS          = 16,
  parameter int MAX_NEIGHBOR_COUNT = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          mode,
  input  logic [31:0]                   vertex_count,
  loop_vertex_smoother_if.master        ram,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int NW     = $clog2(MAX_NEIGHBOR_COUNT + 1);
  localparam int TAB    = 1 << NW;
  localparam int WW     = FRAC_BITS + 2;
  localparam int PW     = DATA_WIDTH + WW;
  localparam int ACC_W  = 2 * DATA_WIDTH + NW;
  localparam int STRIDE = MAX_NEIGHBOR_COUNT + 1;

  localparam logic [ADDR_WIDTH-1:0] A_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_TWO    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_THREE  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_STRIDE = ADDR_WIDTH'(STRIDE);
  localparam logic [NW-1:0]         I_ONE    = NW'(1);
  localparam logic signed [WW-1:0]  W_ONE    = WW'(longint'(1) << FRAC_BITS);

  // Exact Loop beta: valence 3 is the special case 3/16, everything else 3/(8n).
  function automatic longint beta_calc(input int n);
    longint num;
    num = longint'(3) << FRAC_BITS;
    if (n <= 0) return 0;
    if (n == 3) return num / 16;
    return num / longint'(8 * n);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    LD_CNT,
    LD_IDX,
    FETCH_NBR,
    FETCH_SELF,
    WRITE,
    DONE
  } state_t;

  state_t                    state;
  logic [1:0]                ph;
  logic [31:0]               v;
  logic [31:0]               count_r;
  logic                      mode_r;
  logic [ADDR_WIDTH-1:0]     nbr_base;
  logic [ADDR_WIDTH-1:0]     self_addr;
  logic [NW-1:0]             n_r;
  logic [NW-1:0]             i_r;
  logic signed [WW-1:0]      beta_r;
  logic signed [WW-1:0]      wself_r;
  logic signed [ACC_W-1:0]   acc_x;
  logic signed [ACC_W-1:0]   acc_y;
  logic signed [ACC_W-1:0]   acc_z;

  // Weight tables, filled at elaboration. Entries outside 1..MAX are never
  // selected (those valences take the copy path) and hold a harmless identity.
  logic signed [WW-1:0] beta_tab  [TAB];
  logic signed [WW-1:0] wself_tab [TAB];

  for (genvar g = 0; g < TAB; g++) begin : g_weights
    if (g >= 1 && g <= MAX_NEIGHBOR_COUNT) begin : g_valid
      assign beta_tab[g]  = WW'(beta_calc(g));
      assign wself_tab[g] = WW'((longint'(1) << FRAC_BITS) - longint'(g) * beta_calc(g));
    end else begin : g_unused
      assign beta_tab[g]  = '0;
      assign wself_tab[g] = W_ONE;
    end
  end

  // Valence decode straight from the neighbour RAM read data.
  logic [31:0]           n_word;
  logic                  n_bad;
  logic [NW-1:0]         n_idx;
  logic [ADDR_WIDTH-1:0] k_lo;
  logic [ADDR_WIDTH-1:0] k_addr;

  assign n_word = ram.RAM_NBR_Do;
  assign n_bad  = (n_word == 32'd0) || (n_word > 32'(MAX_NEIGHBOR_COUNT));
  assign n_idx  = n_word[NW-1:0];
  assign k_lo   = n_word[ADDR_WIDTH-1:0];
  // 1-based neighbour index k has its x coordinate at 3k-2.
  assign k_addr = (k_lo << 1) + k_lo - A_TWO;

  // One shared multiplier; the self weight applies only while fetching the vertex itself.
  logic signed [DATA_WIDTH-1:0] obj_data;
  logic signed [WW-1:0]         w_cur;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_W-1:0]      prod_ext;

  assign obj_data = signed'(ram.RAM_OBJ_Do);
  assign w_cur    = (state == FETCH_SELF) ? wself_r : beta_r;
  assign prod     = obj_data * w_cur;
  assign prod_ext = ACC_W'(prod);

  // Main controller. The fetch phases are pipelined against the 1-cycle RAM
  // latency: the address register is always one step ahead of the capture.
  // Advancing to the next vertex is folded into the last write cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ph             <= '0;
      v              <= '0;
      count_r        <= '0;
      mode_r         <= 1'b0;
      nbr_base       <= '0;
      self_addr      <= '0;
      n_r            <= '0;
      i_r            <= '0;
      beta_r         <= '0;
      wself_r        <= '0;
      acc_x          <= '0;
      acc_y          <= '0;
      acc_z          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      ram.RAM_OBJ_EN <= 1'b0;
      ram.RAM_OBJ_A  <= '0;
      ram.RAM_NBR_EN <= 1'b0;
      ram.RAM_NBR_A  <= '0;
      ram.RAM_RES_EN <= 1'b0;
      ram.RAM_RES_A  <= '0;
      ram.RAM_RES_WE <= '0;
      ram.RAM_RES_Di <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err       <= 1'b0;
            mode_r    <= mode;
            count_r   <= vertex_count;
            v         <= '0;
            ph        <= '0;
            nbr_base  <= '0;
            self_addr <= A_ONE;
            if (vertex_count == 32'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state          <= LD_CNT;
              busy           <= 1'b1;
              ram.RAM_OBJ_EN <= 1'b1;
              ram.RAM_NBR_EN <= 1'b1;
              ram.RAM_RES_EN <= 1'b1;
              ram.RAM_NBR_A  <= '0;
            end
          end
        end

        LD_CNT: begin
          if (ph == 2'd0) begin
            ph    <= 2'd1;
            acc_x <= '0;
            acc_y <= '0;
            acc_z <= '0;
          end else begin
            ph <= 2'd0;
            if (mode_r || n_bad) begin
              if (!mode_r) err <= 1'b1;
              wself_r       <= W_ONE;
              beta_r        <= '0;
              state         <= FETCH_SELF;
              ram.RAM_OBJ_A <= self_addr;
            end else begin
              n_r           <= n_idx;
              i_r           <= I_ONE;
              beta_r        <= beta_tab[n_idx];
              wself_r       <= wself_tab[n_idx];
              state         <= LD_IDX;
              ram.RAM_NBR_A <= nbr_base + A_ONE;
            end
          end
        end

        LD_IDX: begin
          if (ph == 2'd0) begin
            ph <= 2'd1;
          end else begin
            ph            <= 2'd0;
            state         <= FETCH_NBR;
            ram.RAM_OBJ_A <= k_addr;
          end
        end

        FETCH_NBR, FETCH_SELF: begin
          ph <= ph + 2'd1;
          if (ph == 2'd0 || ph == 2'd1) ram.RAM_OBJ_A <= ram.RAM_OBJ_A + A_ONE;
          if (ph == 2'd1) acc_x <= acc_x + prod_ext;
          if (ph == 2'd2) acc_y <= acc_y + prod_ext;
          if (ph == 2'd3) begin
            acc_z <= acc_z + prod_ext;
            if (state == FETCH_NBR) begin
              if (i_r == n_r) begin
                state         <= FETCH_SELF;
                ram.RAM_OBJ_A <= self_addr;
              end else begin
                i_r           <= i_r + I_ONE;
                ram.RAM_NBR_A <= ram.RAM_NBR_A + A_ONE;
                state         <= LD_IDX;
              end
            end else begin
              // x is already final here; y and z settle before their write slots.
              state          <= WRITE;
              ram.RAM_RES_A  <= self_addr;
              ram.RAM_RES_WE <= 4'hF;
              ram.RAM_RES_Di <= DATA_WIDTH'(acc_x >>> FRAC_BITS);
            end
          end
        end

        WRITE: begin
          ph <= ph + 2'd1;
          if (ph == 2'd0) begin
            ram.RAM_RES_A  <= ram.RAM_RES_A + A_ONE;
            ram.RAM_RES_Di <= DATA_WIDTH'(acc_y >>> FRAC_BITS);
          end else if (ph == 2'd1) begin
            ram.RAM_RES_A  <= ram.RAM_RES_A + A_ONE;
            ram.RAM_RES_Di <= DATA_WIDTH'(acc_z >>> FRAC_BITS);
          end else begin
            ph             <= 2'd0;
            ram.RAM_RES_WE <= '0;
            if (v + 32'd1 == count_r) begin
              state          <= DONE;
              done           <= 1'b1;
              busy           <= 1'b0;
              ram.RAM_OBJ_EN <= 1'b0;
              ram.RAM_NBR_EN <= 1'b0;
              ram.RAM_RES_EN <= 1'b0;
              ram.RAM_OBJ_A  <= '0;
              ram.RAM_NBR_A  <= '0;
              ram.RAM_RES_A  <= '0;
              ram.RAM_RES_Di <= '0;
            end else begin
              v             <= v + 32'd1;
              nbr_base      <= nbr_base + A_STRIDE;
              ram.RAM_NBR_A <= nbr_base + A_STRIDE;
              self_addr     <= self_addr + A_THREE;
              state         <= LD_CNT;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loop_vertex_smoother.sv
// tb_loop_vertex_smoother
// Directed self-checking bench for loop_vertex_smoother. Behavioural RAM models
// with 1-cycle read latency sit on the slave side of the interface; each scenario
// task loads memory, runs the block and compares against hand-computed values.
module tb_loop_vertex_smoother;

  localparam int AW     = 9;
  localparam int DW     = 32;
  localparam int FB     = 16;
  localparam int MNC    = 10;
  localparam int STRIDE = MNC + 1;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] vertex_count = 32'd0;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int done_total = 0;
  logic clear_res = 1'b0;

  logic [31:0] obj_mem [0:511];
  logic [31:0] nbr_mem [0:511];
  logic [31:0] res_mem [0:511];

  loop_vertex_smoother_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram ();

  loop_vertex_smoother #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .FRAC_BITS(FB),
    .MAX_NEIGHBOR_COUNT(MNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mode(mode),
    .vertex_count(vertex_count),
    .ram(ram),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  // RAM models plus a running count of done pulses.
  always @(posedge clk) begin
    if (ram.RAM_OBJ_EN) ram.RAM_OBJ_Do <= obj_mem[ram.RAM_OBJ_A];
    if (ram.RAM_NBR_EN) ram.RAM_NBR_Do <= nbr_mem[ram.RAM_NBR_A];
    if (clear_res) begin
      for (int i = 0; i < 512; i++) res_mem[i] <= SENT;
    end else if (ram.RAM_RES_EN) begin
      for (int b = 0; b < 4; b++)
        if (ram.RAM_RES_WE[b]) res_mem[ram.RAM_RES_A][b*8 +: 8] <= ram.RAM_RES_Di[b*8 +: 8];
    end
    if (done) done_total <= done_total + 1;
  end

  task automatic clear_mems();
    for (int i = 0; i < 512; i++) begin
      obj_mem[i] = 32'd0;
      nbr_mem[i] = 32'd0;
    end
    @(negedge clk);
    clear_res = 1'b1;
    @(negedge clk);
    clear_res = 1'b0;
  endtask

  task automatic clear_results();
    @(negedge clk);
    clear_res = 1'b1;
    @(negedge clk);
    clear_res = 1'b0;
  endtask

  // Starts a run and waits (bounded) for done. Optionally pulses a second start mid-run.
  task automatic applyStimulus(input logic m, input logic [31:0] cnt, input int inject_at,
                               output int cyc_done, output int busy_cyc, output int pulses,
                               output logic err_c1);
    int  base;
    int  cyc;
    bit  seen;
    base = done_total;
    cyc = 0;
    busy_cyc = 0;
    cyc_done = 0;
    seen = 0;
    err_c1 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    mode = m;
    vertex_count = cnt;
    while (!seen && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (inject_at != 0 && cyc == inject_at) begin
        start = 1'b1;
        mode = 1'b0;
        vertex_count = cnt + 32'd3;
      end
      if (cyc == 1) err_c1 = err;
      if (busy) busy_cyc++;
      if (done) begin
        seen = 1;
        cyc_done = cyc;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL run_timeout: got no done within %0d cycles, expected a done pulse", cyc);
    end
    repeat (4) @(posedge clk);
    #1;
    pulses = done_total - base;
  endtask

  // Vertex 0 with valence n and neighbours k = first_k .. first_k+n-1.
  task automatic set_neighbours(input int base, input int n, input int first_k);
    nbr_mem[base] = n;
    for (int i = 0; i < n; i++) nbr_mem[base + 1 + i] = first_k + i;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got busy=%b done=%b err=%b, expected 0 0 0", busy, done, err);
    end
    checks++;
    if ({ram.RAM_OBJ_EN, ram.RAM_NBR_EN, ram.RAM_RES_EN} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_enables: got %b, expected 000",
               {ram.RAM_OBJ_EN, ram.RAM_NBR_EN, ram.RAM_RES_EN});
    end
    checks++;
    if (ram.RAM_OBJ_A !== '0 || ram.RAM_NBR_A !== '0 || ram.RAM_RES_A !== '0) begin
      errors++;
      $display("[TB] FAIL reset_addr: got %h %h %h, expected 0 0 0",
               ram.RAM_OBJ_A, ram.RAM_NBR_A, ram.RAM_RES_A);
    end
    checks++;
    if (ram.RAM_RES_WE !== 4'h0 || ram.RAM_RES_Di !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_write: got WE=%h Di=%h, expected 0 0", ram.RAM_RES_WE, ram.RAM_RES_Di);
    end
    rst = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_zero_count();
    int cd, bc, pl;
    logic e1;
    clear_mems();
    applyStimulus(1'b0, 32'd0, 0, cd, bc, pl, e1);
    checks++;
    if (cd != 1 || bc != 0) begin
      errors++;
      $display("[TB] FAIL zero_count_timing: got done at %0d busy %0d, expected 1 and 0", cd, bc);
    end
    checks++;
    if (res_mem[1] !== SENT) begin
      errors++;
      $display("[TB] FAIL zero_count_nowrite: got %h, expected %h", res_mem[1], SENT);
    end
  endtask

  task automatic load_valence3();
    clear_mems();
    set_neighbours(0, 3, 2);
    for (int k = 2; k <= 4; k++) obj_mem[3*k-2] = 32'h0001_0000;
  endtask

  task automatic test_valence3();
    int cd, bc, pl;
    logic e1;
    load_valence3();
    applyStimulus(1'b0, 32'd1, 0, cd, bc, pl, e1);
    checks++;
    if (res_mem[1] !== 32'h9000 || res_mem[2] !== 32'd0 || res_mem[3] !== 32'd0) begin
      errors++;
      $display("[TB] FAIL v3_result: got %h %h %h, expected 00009000 0 0", res_mem[1], res_mem[2], res_mem[3]);
    end
    checks++;
    if (bc != 27 || cd != 28) begin
      errors++;
      $display("[TB] FAIL v3_timing: got busy %0d done at %0d, expected 27 and 28", bc, cd);
    end
    checks++;
    if (pl != 1) begin
      errors++;
      $display("[TB] FAIL v3_done_pulses: got %0d, expected 1", pl);
    end
  endtask

  task automatic test_valence6();
    int cd, bc, pl;
    logic e1;
    clear_mems();
    set_neighbours(0, 6, 2);
    for (int a = 1; a <= 3; a++) obj_mem[a] = 32'h0002_0000;
    applyStimulus(1'b0, 32'd1, 0, cd, bc, pl, e1);
    checks++;
    if (res_mem[1] !== 32'h14000 || res_mem[2] !== 32'h14000 || res_mem[3] !== 32'h14000) begin
      errors++;
      $display("[TB] FAIL v6_pos: got %h %h %h, expected 00014000 x3", res_mem[1], res_mem[2], res_mem[3]);
    end
    checks++;
    if (bc != 45) begin
      errors++;
      $display("[TB] FAIL v6_busy: got %0d, expected 45", bc);
    end
    for (int a = 1; a <= 3; a++) obj_mem[a] = 32'hFFFE_0000;
    clear_results();
    applyStimulus(1'b0, 32'd1, 0, cd, bc, pl, e1);
    checks++;
    if (res_mem[1] !== 32'hFFFEC000 || res_mem[2] !== 32'hFFFEC000 || res_mem[3] !== 32'hFFFEC000) begin
      errors++;
      $display("[TB] FAIL v6_neg: got %h %h %h, expected fffec000 x3", res_mem[1], res_mem[2], res_mem[3]);
    end
  endtask

  // Valence 4: beta 0x1800, self weight 0xA000; exercises floor on negative and fractional sums.
  task automatic test_valence4_floor();
    int cd, bc, pl;
    logic e1;
    clear_mems();
    set_neighbours(0, 4, 2);
    for (int k = 2; k <= 5; k++) begin
      obj_mem[3*k-1] = 32'h0001_0000;
      obj_mem[3*k]   = 32'h0001_0000;
    end
    obj_mem[1] = 32'hFFFF_FFFF;
    obj_mem[2] = 32'h0001_0000;
    obj_mem[3] = 32'h0000_0003;
    applyStimulus(1'b0, 32'd1, 0, cd, bc, pl, e1);
    checks++;
    if (res_mem[1] !== 32'hFFFF_FFFF || res_mem[2] !== 32'h0001_0000 || res_mem[3] !== 32'h0000_6001) begin
      errors++;
      $display("[TB] FAIL v4_floor: got %h %h %h, expected ffffffff 00010000 00006001",
               res_mem[1], res_mem[2], res_mem[3]);
    end
    checks++;
    if (bc != 33) begin
      errors++;
      $display("[TB] FAIL v4_busy: got %0d, expected 33", bc);
    end
  endtask

  task automatic test_copy_mode();
    int cd, bc, pl;
    logic e1;
    clear_mems();
    nbr_mem[0] = 3;
    nbr_mem[STRIDE] = 6;
    nbr_mem[2*STRIDE] = 2;
    nbr_mem[3*STRIDE] = 5;
    for (int a = 1; a <= 12; a++) obj_mem[a] = 32'h8000_0123 + a * 32'h0101_1111;
    applyStimulus(1'b1, 32'd4, 0, cd, bc, pl, e1);
    for (int a = 1; a <= 12; a++) begin
      checks++;
      if (res_mem[a] !== obj_mem[a]) begin
        errors++;
        $display("[TB] FAIL copy_word%0d: got %h, expected %h", a, res_mem[a], obj_mem[a]);
      end
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL copy_err: got %b, expected 0", err);
    end
    checks++;
    if (bc != 36) begin
      errors++;
      $display("[TB] FAIL copy_busy: got %0d, expected 36", bc);
    end
  endtask

  task automatic test_malformed();
    int cd, bc, pl;
    logic e1;
    clear_mems();
    set_neighbours(0, 3, 3);
    nbr_mem[STRIDE] = 0;
    for (int k = 3; k <= 5; k++) obj_mem[3*k-2] = 32'h0001_0000;
    obj_mem[4] = 32'h0001_2345;
    obj_mem[5] = 32'hFFFF_FFF9;
    obj_mem[6] = 32'h0001_0000;
    applyStimulus(1'b0, 32'd2, 0, cd, bc, pl, e1);
    checks++;
    if (res_mem[1] !== 32'h9000 || res_mem[2] !== 32'd0 || res_mem[3] !== 32'd0) begin
      errors++;
      $display("[TB] FAIL bad0_v0: got %h %h %h, expected 00009000 0 0", res_mem[1], res_mem[2], res_mem[3]);
    end
    checks++;
    if (res_mem[4] !== 32'h0001_2345 || res_mem[5] !== 32'hFFFF_FFF9 || res_mem[6] !== 32'h0001_0000) begin
      errors++;
      $display("[TB] FAIL bad0_v1: got %h %h %h, expected 00012345 fffffff9 00010000",
               res_mem[4], res_mem[5], res_mem[6]);
    end
    checks++;
    if (err !== 1'b1 || bc != 36) begin
      errors++;
      $display("[TB] FAIL bad0_err: got err=%b busy=%0d, expected 1 and 36", err, bc);
    end
    // Valence above the maximum also copies and flags; the accepted start clears err first.
    nbr_mem[0] = 11;
    obj_mem[1] = 32'h0000_0005;
    obj_mem[2] = 32'hFFFF_0000;
    obj_mem[3] = 32'h7FFF_FFFF;
    clear_results();
    applyStimulus(1'b0, 32'd1, 0, cd, bc, pl, e1);
    checks++;
    if (e1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear_on_start: got %b, expected 0", e1);
    end
    checks++;
    if (res_mem[1] !== 32'h5 || res_mem[2] !== 32'hFFFF_0000 || res_mem[3] !== 32'h7FFF_FFFF || err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bad11: got %h %h %h err=%b, expected 00000005 ffff0000 7fffffff err=1",
               res_mem[1], res_mem[2], res_mem[3], err);
    end
    nbr_mem[0] = 3;
    for (int a = 1; a <= 3; a++) obj_mem[a] = 32'd0;
    applyStimulus(1'b0, 32'd1, 0, cd, bc, pl, e1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_after_valid: got %b, expected 0", err);
    end
  endtask

  task automatic test_reset_mid_write();
    int cyc;
    int base;
    int cd, bc, pl;
    logic e1;
    load_valence3();
    @(negedge clk);
    start = 1'b1;
    mode = 1'b0;
    vertex_count = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (ram.RAM_RES_WE !== 4'hF && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc != 25) begin
      errors++;
      $display("[TB] FAIL first_write_cycle: got %0d, expected 25", cyc);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    base = done_total;
    @(posedge clk);
    #1;
    checks++;
    if (ram.RAM_RES_WE !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_state: got WE=%h busy=%b done=%b, expected 0 0 0",
               ram.RAM_RES_WE, busy, done);
    end
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (done_total != base || res_mem[3] !== SENT) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: got done pulses %0d z=%h, expected 0 and %h",
               done_total - base, res_mem[3], SENT);
    end
    clear_results();
    applyStimulus(1'b0, 32'd1, 0, cd, bc, pl, e1);
    checks++;
    if (res_mem[1] !== 32'h9000 || res_mem[2] !== 32'd0 || res_mem[3] !== 32'd0 || bc != 27) begin
      errors++;
      $display("[TB] FAIL restart_result: got %h %h %h busy %0d, expected 00009000 0 0 busy 27",
               res_mem[1], res_mem[2], res_mem[3], bc);
    end
  endtask

  task automatic test_start_while_busy();
    int cd, bc, pl;
    logic e1;
    clear_mems();
    for (int a = 1; a <= 15; a++) obj_mem[a] = 32'h0000_1000 + a;
    applyStimulus(1'b1, 32'd2, 5, cd, bc, pl, e1);
    checks++;
    if (bc != 18 || cd != 19) begin
      errors++;
      $display("[TB] FAIL busy_start_timing: got busy %0d done at %0d, expected 18 and 19", bc, cd);
    end
    checks++;
    if (pl != 1) begin
      errors++;
      $display("[TB] FAIL busy_start_pulses: got %0d, expected 1", pl);
    end
    checks++;
    if (res_mem[6] !== 32'h0000_1006 || res_mem[7] !== SENT) begin
      errors++;
      $display("[TB] FAIL busy_start_extent: got %h %h, expected 00001006 %h", res_mem[6], res_mem[7], SENT);
    end
  endtask

  initial begin
    test_reset();
    test_zero_count();
    test_valence3();
    test_valence6();
    test_valence4_floor();
    test_copy_mode();
    test_malformed();
    test_reset_mid_write();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
